// File: rtl/cpu_clk_sched.sv
// Clock-enable scheduler: issues a one-cycle tick in the clk_in domain while
// sequencing HALT / RUN / single STEP, and counts issued ticks.
module cpu_clk_sched #(
   parameter int          CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 32'd50_000_000
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             div_wr,
   input  logic [CNT_W-1:0] div_val,
   output logic             div_ack,
   output logic             div_err,
   output logic             tick,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] tick_count
);

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);

   state_t           state_r, state_next_s;
   logic [CNT_W-1:0] cnt_r, cnt_next_s;
   logic [CNT_W-1:0] div_reg_r;
   logic [CNT_W-1:0] div_eff_s;
   logic [CNT_W-1:0] tick_count_r;
   logic             tick_r, tick_next_s;
   logic             step_q_r;
   logic             step_edge_s;
   logic             tc_s;
   logic             div_ack_r, div_err_r;

   // Effective divide, terminal count and step edge detection
   always_comb begin
      div_eff_s   = (div_reg_r == CNT_ZERO) ? CNT_ONE : div_reg_r;
      tc_s        = (cnt_r == (div_eff_s - CNT_ONE));
      step_edge_s = step_req & ~step_q_r;
   end

   // Next-state, counter and tick decode
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      tick_next_s  = 1'b0;
      case (state_r)
         ST_HALT: begin
            cnt_next_s = CNT_ZERO;
            if (halt_req) begin
               state_next_s = ST_HALT;
            end else if (run_req) begin
               state_next_s = ST_RUN;
            end else if (step_edge_s) begin
               state_next_s = ST_STEP;
            end else begin
               state_next_s = ST_HALT;
            end
         end
         ST_RUN, ST_STEP: begin
            if (halt_req) begin
               state_next_s = ST_HALT;
               cnt_next_s   = CNT_ZERO;
            end else if (tc_s) begin
               cnt_next_s   = CNT_ZERO;
               tick_next_s  = 1'b1;
               // a step ends on its single tick
               state_next_s = (state_r == ST_STEP) ? ST_HALT : ST_RUN;
            end else begin
               cnt_next_s   = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_next_s = ST_HALT;
            cnt_next_s   = CNT_ZERO;
         end
      endcase
   end

   // Sequencer state, counter, tick and tick counter
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_r      <= ST_HALT;
         cnt_r        <= CNT_ZERO;
         tick_r       <= 1'b0;
         tick_count_r <= CNT_ZERO;
         step_q_r     <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         cnt_r    <= cnt_next_s;
         tick_r   <= tick_next_s;
         step_q_r <= step_req;
         if (tick_next_s) begin
            tick_count_r <= tick_count_r + CNT_ONE;
         end else begin
            tick_count_r <= tick_count_r;
         end
      end
   end

   // Divide register: writable only while halted, acknowledged or rejected next cycle
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         div_reg_r <= DIV_RST;
         div_ack_r <= 1'b0;
         div_err_r <= 1'b0;
      end else begin
         div_ack_r <= div_wr & (state_r == ST_HALT);
         div_err_r <= div_wr & (state_r != ST_HALT);
         if (div_wr && (state_r == ST_HALT)) begin
            div_reg_r <= div_val;
         end else begin
            div_reg_r <= div_reg_r;
         end
      end
   end

   assign div_ack    = div_ack_r;
   assign div_err    = div_err_r;
   assign tick       = tick_r;
   assign state      = state_r;
   assign tick_count = tick_count_r;

endmodule
